// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy and threshold status, sticky
// overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_EN,
  input  logic                    i_Wr_En,
  input  logic [DATA_WIDTH-1:0]   i_Wr_Data,
  input  logic                    i_Rd_En,
  input  logic                    i_Err_Clr,
  output logic [DATA_WIDTH-1:0]   o_Rd_Data,
  output logic                    o_Rd_Valid,
  output logic                    o_Full,
  output logic                    o_Empty,
  output logic                    o_Almost_Full,
  output logic                    o_Almost_Empty,
  output logic [$clog2(DEPTH):0]  o_Count,
  output logic                    o_Overflow,
  output logic                    o_Underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
    $error("sync_fifo_param: almost-full/almost-empty thresholds out of range");
  end

  logic [DATA_WIDTH-1:0] r_Mem [DEPTH];

  logic [PTR_W-1:0]  r_Wr_Ptr;
  logic [PTR_W-1:0]  r_Rd_Ptr;
  logic [PTR_W-1:0]  r_Count;
  logic              r_Full;
  logic              r_Empty;
  logic              r_Almost_Full;
  logic              r_Almost_Empty;
  logic              r_Overflow;
  logic              r_Underflow;

  logic              w_Wr_Acc;
  logic              w_Rd_Acc;
  logic [ADDR_W-1:0] w_Wr_Addr;
  logic [ADDR_W-1:0] w_Rd_Addr;
  logic [PTR_W-1:0]  w_Wr_Ptr_Nxt;
  logic [PTR_W-1:0]  w_Rd_Ptr_Nxt;
  logic [PTR_W-1:0]  w_Count_Nxt;

  // Acceptance looks only at the registered flags, so a slot freed or filled
  // this cycle never becomes usable until the next one.
  assign w_Wr_Acc     = i_EN & i_Wr_En & ~r_Full;
  assign w_Rd_Acc     = i_EN & i_Rd_En & ~r_Empty;
  assign w_Wr_Addr    = r_Wr_Ptr[ADDR_W-1:0];
  assign w_Rd_Addr    = r_Rd_Ptr[ADDR_W-1:0];
  assign w_Wr_Ptr_Nxt = w_Wr_Acc ? (r_Wr_Ptr + PTR_ONE) : r_Wr_Ptr;
  assign w_Rd_Ptr_Nxt = w_Rd_Acc ? (r_Rd_Ptr + PTR_ONE) : r_Rd_Ptr;
  assign w_Count_Nxt  = w_Wr_Ptr_Nxt - w_Rd_Ptr_Nxt;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Wr_Ptr       <= '0;
      r_Rd_Ptr       <= '0;
      r_Count        <= '0;
      r_Full         <= 1'b0;
      r_Empty        <= 1'b1;
      r_Almost_Full  <= 1'b0;
      r_Almost_Empty <= 1'b1;
    end else if (i_EN) begin
      r_Wr_Ptr       <= w_Wr_Ptr_Nxt;
      r_Rd_Ptr       <= w_Rd_Ptr_Nxt;
      r_Count        <= w_Count_Nxt;
      r_Full         <= (w_Count_Nxt == DEPTH_C);
      r_Empty        <= (w_Count_Nxt == '0);
      r_Almost_Full  <= (w_Count_Nxt >= AF_C);
      r_Almost_Empty <= (w_Count_Nxt <= AE_C);
    end
  end

  // A fresh offending request wins over a clear arriving in the same cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Overflow  <= 1'b0;
      r_Underflow <= 1'b0;
    end else if (i_EN) begin
      if (i_Wr_En && r_Full) begin
        r_Overflow <= 1'b1;
      end else if (i_Err_Clr) begin
        r_Overflow <= 1'b0;
      end
      if (i_Rd_En && r_Empty) begin
        r_Underflow <= 1'b1;
      end else if (i_Err_Clr) begin
        r_Underflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset && w_Wr_Acc) begin
      r_Mem[w_Wr_Addr] <= i_Wr_Data;
    end
  end

  if (FWFT == 0) begin : g_std_read
    logic [DATA_WIDTH-1:0] r_Rd_Data;
    logic                  r_Rd_Valid;

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        r_Rd_Data  <= '0;
        r_Rd_Valid <= 1'b0;
      end else begin
        r_Rd_Valid <= w_Rd_Acc;
        if (w_Rd_Acc) begin
          r_Rd_Data <= r_Mem[w_Rd_Addr];
        end
      end
    end

    assign o_Rd_Data  = r_Rd_Data;
    assign o_Rd_Valid = r_Rd_Valid;
  end else begin : g_fwft_read
    // Head word is presented directly; forced to zero while empty so reset
    // and drained states never expose stale storage.
    assign o_Rd_Data  = r_Empty ? '0 : r_Mem[w_Rd_Addr];
    assign o_Rd_Valid = ~r_Empty;
  end

  assign o_Full         = r_Full;
  assign o_Empty        = r_Empty;
  assign o_Almost_Full  = r_Almost_Full;
  assign o_Almost_Empty = r_Almost_Empty;
  assign o_Count        = r_Count;
  assign o_Overflow     = r_Overflow;
  assign o_Underflow    = r_Underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Checks a registered-read and a first-word-fall-through FIFO, driven in lockstep,
// against a queue-based model plus directed literal expectations.
module tb_sync_fifo_param;

  localparam int DW    = 128;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;
  localparam int CW    = 4;

  logic          i_Clk = 1'b0;
  logic          i_Reset;
  logic          i_EN;
  logic          i_Wr_En;
  logic [DW-1:0] i_Wr_Data;
  logic          i_Rd_En;
  logic          i_Err_Clr;

  logic [DW-1:0] s_Rd_Data, f_Rd_Data;
  logic          s_Rd_Valid, f_Rd_Valid;
  logic          s_Full, f_Full, s_Empty, f_Empty;
  logic          s_Almost_Full, f_Almost_Full, s_Almost_Empty, f_Almost_Empty;
  logic [CW-1:0] s_Count, f_Count;
  logic          s_Overflow, f_Overflow, s_Underflow, f_Underflow;

  int assertCount = 0;
  int failCount   = 0;

  logic [DW-1:0] modelQ[$];
  logic          modelOvf;
  logic          modelUnf;
  logic          modelStdValid;
  logic [DW-1:0] modelStdData;
  bit            checkOn = 1'b0;

  always #5 i_Clk = ~i_Clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(0)) dutStd (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_EN(i_EN), .i_Wr_En(i_Wr_En), .i_Wr_Data(i_Wr_Data),
    .i_Rd_En(i_Rd_En), .i_Err_Clr(i_Err_Clr), .o_Rd_Data(s_Rd_Data), .o_Rd_Valid(s_Rd_Valid),
    .o_Full(s_Full), .o_Empty(s_Empty), .o_Almost_Full(s_Almost_Full),
    .o_Almost_Empty(s_Almost_Empty), .o_Count(s_Count), .o_Overflow(s_Overflow),
    .o_Underflow(s_Underflow)
  );

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET), .FWFT(1)) dutFwft (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_EN(i_EN), .i_Wr_En(i_Wr_En), .i_Wr_Data(i_Wr_Data),
    .i_Rd_En(i_Rd_En), .i_Err_Clr(i_Err_Clr), .o_Rd_Data(f_Rd_Data), .o_Rd_Valid(f_Rd_Valid),
    .o_Full(f_Full), .o_Empty(f_Empty), .o_Almost_Full(f_Almost_Full),
    .o_Almost_Empty(f_Almost_Empty), .o_Count(f_Count), .o_Overflow(f_Overflow),
    .o_Underflow(f_Underflow)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic wr,
                               input logic [DW-1:0] d, input logic rd, input logic clr);
    i_Reset   = rst;
    i_EN      = en;
    i_Wr_En   = wr;
    i_Wr_Data = d;
    i_Rd_En   = rd;
    i_Err_Clr = clr;
    @(negedge i_Clk);
    #1;
  endtask

  // Reference model: a queue of stored words plus error flags, advanced once per rising edge
  always @(posedge i_Clk) begin
    int  sz;
    bit  wrAcc;
    bit  rdAcc;
    sz = modelQ.size();
    if (i_Reset) begin
      modelQ.delete();
      modelOvf      = 1'b0;
      modelUnf      = 1'b0;
      modelStdValid = 1'b0;
      modelStdData  = '0;
      checkOn       = 1'b1;
    end else if (i_EN) begin
      wrAcc = i_Wr_En && (sz < DEPTH);
      rdAcc = i_Rd_En && (sz > 0);
      if (rdAcc) begin
        modelStdData  = modelQ.pop_front();
        modelStdValid = 1'b1;
      end else begin
        modelStdValid = 1'b0;
      end
      if (wrAcc) modelQ.push_back(i_Wr_Data);
      if (i_Wr_En && sz == DEPTH) modelOvf = 1'b1;
      else if (i_Err_Clr)         modelOvf = 1'b0;
      if (i_Rd_En && sz == 0)     modelUnf = 1'b1;
      else if (i_Err_Clr)         modelUnf = 1'b0;
    end else begin
      modelStdValid = 1'b0;
    end
  end

  // Compare both DUTs against the model every falling edge once reset has been seen
  always @(negedge i_Clk) begin
    int sz;
    if (checkOn) begin
      sz = modelQ.size();
      checkOutput("std_count", DW'(s_Count), DW'(sz));
      checkOutput("fwft_count", DW'(f_Count), DW'(sz));
      checkFlag("std_full", s_Full, sz == DEPTH);
      checkFlag("fwft_full", f_Full, sz == DEPTH);
      checkFlag("std_empty", s_Empty, sz == 0);
      checkFlag("fwft_empty", f_Empty, sz == 0);
      checkFlag("std_afull", s_Almost_Full, sz >= AFT);
      checkFlag("fwft_afull", f_Almost_Full, sz >= AFT);
      checkFlag("std_aempty", s_Almost_Empty, sz <= AET);
      checkFlag("fwft_aempty", f_Almost_Empty, sz <= AET);
      checkFlag("std_ovf", s_Overflow, modelOvf);
      checkFlag("fwft_ovf", f_Overflow, modelOvf);
      checkFlag("std_unf", s_Underflow, modelUnf);
      checkFlag("fwft_unf", f_Underflow, modelUnf);
      checkFlag("std_valid", s_Rd_Valid, modelStdValid);
      checkOutput("std_data", s_Rd_Data, modelStdData);
      checkFlag("fwft_valid", f_Rd_Valid, sz > 0);
      if (sz > 0) checkOutput("fwft_data", f_Rd_Data, modelQ[0]);
    end
  end

  initial begin
    logic [DW-1:0] expWord;
    i_Reset   = 1'b1;
    i_EN      = 1'b0;
    i_Wr_En   = 1'b0;
    i_Wr_Data = '0;
    i_Rd_En   = 1'b0;
    i_Err_Clr = 1'b0;
    @(negedge i_Clk);
    #1;

    // Reset with enable low
    applyStimulus(1, 0, 0, '0, 0, 0);
    checkFlag("rst_empty", s_Empty, 1'b1);
    checkFlag("rst_aempty", s_Almost_Empty, 1'b1);
    checkOutput("rst_count", DW'(s_Count), DW'(0));
    checkFlag("rst_ovf", s_Overflow, 1'b0);
    checkFlag("rst_unf", s_Underflow, 1'b0);
    checkFlag("rst_valid", s_Rd_Valid, 1'b0);
    checkFlag("rst_fvalid", f_Rd_Valid, 1'b0);

    // Fill with 1..8 and watch threshold crossings
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(0, 1, 1, DW'(i), 0, 0);
      checkOutput("fill_count", DW'(s_Count), DW'(i));
      checkFlag("fill_aempty", s_Almost_Empty, i <= 2);
      checkFlag("fill_afull", s_Almost_Full, i >= 6);
      checkFlag("fill_full", s_Full, i == 8);
    end
    applyStimulus(0, 1, 1, DW'(9), 0, 0);
    checkFlag("ovf_set", s_Overflow, 1'b1);
    checkOutput("ovf_count", DW'(s_Count), DW'(8));
    checkOutput("fwft_head", f_Rd_Data, DW'(1));

    // Drain and then read once more while empty
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(0, 1, 0, '0, 1, 0);
      checkOutput("drain_data", s_Rd_Data, DW'(i));
      checkFlag("drain_valid", s_Rd_Valid, 1'b1);
    end
    applyStimulus(0, 1, 0, '0, 1, 0);
    checkFlag("unf_set", s_Underflow, 1'b1);
    checkFlag("unf_valid", s_Rd_Valid, 1'b0);
    checkOutput("unf_hold", s_Rd_Data, DW'(8));
    applyStimulus(0, 1, 0, '0, 0, 1);
    checkFlag("clr_ovf", s_Overflow, 1'b0);
    checkFlag("clr_unf", s_Underflow, 1'b0);

    // Steady read+write at count 4 across several pointer wraps
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, DW'(16 + i), 0, 0);
    for (int j = 0; j < 20; j++) begin
      applyStimulus(0, 1, 1, DW'(32 + j), 1, 0);
      expWord = (j < 4) ? DW'(16 + j) : DW'(32 + j - 4);
      checkOutput("steady_count", DW'(s_Count), DW'(4));
      checkOutput("steady_data", s_Rd_Data, expWord);
    end

    // Full with both requests, then empty with both requests
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, DW'(64 + i), 0, 0);
    applyStimulus(0, 1, 1, DW'(99), 1, 0);
    checkOutput("fullrw_count", DW'(s_Count), DW'(7));
    checkFlag("fullrw_ovf", s_Overflow, 1'b1);
    applyStimulus(0, 1, 0, '0, 0, 1);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, '0, 1, 0);
    applyStimulus(0, 1, 1, DW'(77), 1, 0);
    checkOutput("emptyrw_count", DW'(s_Count), DW'(1));
    checkFlag("emptyrw_unf", s_Underflow, 1'b1);
    checkOutput("emptyrw_fdata", f_Rd_Data, DW'(77));

    // Fall-through behaviour after a fresh reset
    applyStimulus(1, 0, 0, '0, 0, 0);
    applyStimulus(0, 1, 1, DW'('hA), 0, 0);
    checkOutput("fwft_a", f_Rd_Data, DW'('hA));
    checkFlag("fwft_a_valid", f_Rd_Valid, 1'b1);
    applyStimulus(0, 1, 1, DW'('hB), 0, 0);
    checkOutput("fwft_a_hold", f_Rd_Data, DW'('hA));
    applyStimulus(0, 1, 0, '0, 1, 0);
    checkOutput("fwft_b", f_Rd_Data, DW'('hB));

    // Enable low freezes state despite requests
    applyStimulus(0, 0, 1, DW'('hC), 1, 1);
    checkOutput("frz_count", DW'(f_Count), DW'(1));
    checkOutput("frz_fdata", f_Rd_Data, DW'('hB));
    checkFlag("frz_valid", s_Rd_Valid, 1'b0);

    // Reset mid-operation at count 5
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, DW'(128 + i), 0, 0);
    checkOutput("pre_rst_count", DW'(s_Count), DW'(5));
    applyStimulus(1, 1, 1, DW'(200), 1, 0);
    checkOutput("mid_rst_count", DW'(s_Count), DW'(0));
    checkFlag("mid_rst_empty", f_Empty, 1'b1);

    // Randomized traffic alternating write-heavy and read-heavy phases
    for (int c = 0; c < 3000; c++) begin
      int wrPct;
      wrPct = (((c / 150) % 2) == 0) ? 75 : 30;
      applyStimulus($urandom_range(0, 249) == 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 99) < wrPct,
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    $urandom_range(0, 99) < (100 - wrPct),
                    $urandom_range(0, 19) == 0);
    end

    applyStimulus(0, 1, 0, '0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
